jtag_tap_responder: RTL and testbench
=====================================

// Module: jtag_tap_responder
// PURPOSE
//  Target-side JTAG TAP: the responder at the far end of the GPIO bit-banged JTAG initiator.
//  Oversamples asynchronous TCK/TMS/TDI in the system clock domain and runs the IEEE 1149.1 16-state TAP.
//  Implements IR plus IDCODE, BYPASS and one USER data register.
//  USER gives soft-core firmware a loopback/debug mailbox over the same four wires.
// PARAMETERS
//  IR_WIDTH       4             instruction register width (>=2)
//  IDCODE_VALUE   32'h10001FFF  value captured by IDCODE; bit0 must be 1
//  IR_IDCODE      4'b0001       IDCODE opcode; also the IR value after Test-Logic-Reset
//  IR_USER        4'b1000       USER data-register opcode
//  USER_DR_WIDTH  32            USER shift/update register width (>=2)
//  SYNC_STAGES    2             flip-flop synchroniser depth on tck/tms/tdi (>=2)
// PORTS
//  clk                input   1              system clock; all state on rising edge
//  reset              input   1              asynchronous, active-high reset
//  jtag_tck           input   1              JTAG clock pin, asynchronous to clk
//  jtag_tms           input   1              JTAG mode-select pin
//  jtag_tdi           input   1              JTAG data in (from initiator)
//  jtag_tdo           output  1              JTAG data out (to initiator)
//  jtag_tdo_oe        output  1              1 while in Shift-IR/Shift-DR
//  user_capture_data  input   USER_DR_WIDTH  loaded into USER shifter at Capture-DR
//  user_update_data   output  USER_DR_WIDTH  USER shifter contents latched at Update-DR
//  user_update_valid  output  1              1-clk pulse when user_update_data changes
//  tap_state          output  4              current TAP state (shared encoding)
// BEHAVIOUR
//  Reset values: state=Test-Logic-Reset, IR=IR_IDCODE, jtag_tdo=0, jtag_tdo_oe=0.
//    Also user_update_data=0, user_update_valid=0, synchronisers=0.
//  Sampling:
//    - tck/tms/tdi pass through identical SYNC_STAGES chains, so they stay aligned.
//    - A registered copy of synced tck gives rise/fall strobes.
//    - Rise strobe occurs SYNC_STAGES+1 clk after the pin edge.
//  TCK constraint: each TCK level held >=3 clk. Faster TCK is unsupported (no detection).
//  On rise strobe: TAP advances per 1149.1 with synced TMS; the shift happens in the pre-advance state.
//    - Capture-IR: IR shifter <= {0..0,2'b01}.
//    - Shift-IR: IR shifter >>1, tdi into MSB.
//    - Update-IR: IR <= IR shifter.
//    - Capture-DR by IR:
//        IR_IDCODE: 32-bit shifter <= IDCODE_VALUE.
//        IR_USER: shifter <= user_capture_data.
//        any other code: BYPASS, 1-bit shifter <= 0.
//    - Shift-DR: selected shifter >>1, tdi into MSB.
//    - Update-DR with IR_USER: user_update_data <= shifter; user_update_valid pulses next clk for 1 clk.
//    - Entering Test-Logic-Reset: IR <= IR_IDCODE. user_update_data is held (not cleared).
//  On fall strobe:
//    - In Shift-IR/Shift-DR: jtag_tdo <= LSB of the active shifter and jtag_tdo_oe <= 1.
//    - Otherwise: jtag_tdo <= 0 and jtag_tdo_oe <= 0.
//  Boundaries:
//    - Five consecutive TMS=1 rises reach Test-Logic-Reset from any state.
//    - Pause/Exit2 preserve shifter contents.
//    - Shift longer than the register width passes tdi through, delayed by the width.
//    - Unknown IR codes behave as BYPASS.
//    - Async reset mid-shift discards the shifter with no update pulse.
//      First rise after reset release is evaluated from Test-Logic-Reset.
//  tap_state changes the clk after the rise strobe; user_capture_data is sampled on that same strobe.
// STRUCTURE
//  Shared header jtag_tap_defs.vh:
//    - 16 TAP state localparams (4-bit encoding).
//    - Default IR opcodes IR_IDCODE/IR_BYPASS=all-ones/IR_USER.
//  Sub-module jtag_pin_sync: synchroniser chains + tck rise/fall strobes.
//  Top keeps the TAP FSM, IR, shifters, TDO/update registers.
// TESTING
//  1 Reset, then 5x TMS=1 TCK cycles -> tap_state=TLR, IR=0001, tdo_oe=0 throughout.
//  2 TLR->Shift-DR, shift 32 bits -> TDO LSB-first = 32'h10001FFF.
//  3 Shift-IR 4'b1111, then Shift-DR with TDI pattern 1,0,1,1 -> TDO = 0,1,0,1 (1-bit delay).
//  4 IR=1000, user_capture_data=32'hCAFEF00D, shift in 32'h12345678:
//      -> TDO=32'hCAFEF00D;
//      -> at Update-DR user_update_data=32'h12345678 with one 1-clk valid pulse.
//  5 Capture-IR -> first 4 TDO bits = 1,0,0,0 (2'b01 LSB-first).
//  6 Assert reset halfway through a USER shift -> no valid pulse, IR=0001, state=TLR, tdo=0.

Source files
------------

// File: rtl/jtag_tap_responder_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, default opcodes, helpers.
package jtag_tap_responder_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RUN_IDLE   = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_RESET      = 4'hF
  } tap_state_e;

  localparam logic [3:0] IR_IDCODE_DEFAULT = 4'b0001;
  localparam logic [3:0] IR_BYPASS_DEFAULT = 4'b1111;
  localparam logic [3:0] IR_USER_DEFAULT   = 4'b1000;

  function automatic logic is_shift(input tap_state_e s);
    return (s == TAP_SHIFT_DR) || (s == TAP_SHIFT_IR);
  endfunction

endpackage

// File: rtl/jtag_tap_responder_pin_sync.sv
// Synchronises the asynchronous JTAG pins into clk and derives TCK edge strobes.
// All three pins use identical chains so TMS/TDI stay aligned with the TCK edge.
module jtag_tap_responder_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic jtag_tck,
  input  logic jtag_tms,
  input  logic jtag_tdi,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);

  logic [SYNC_STAGES-1:0] tck_sync;
  logic [SYNC_STAGES-1:0] tms_sync;
  logic [SYNC_STAGES-1:0] tdi_sync;
  logic                   tck_p1;

  // Synchroniser chains plus one delayed copy of synced TCK for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_p1   <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[SYNC_STAGES-2:0], jtag_tck};
      tms_sync <= {tms_sync[SYNC_STAGES-2:0], jtag_tms};
      tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], jtag_tdi};
      tck_p1   <= tck_sync[SYNC_STAGES-1];
    end
  end

  assign tck_rise = tck_sync[SYNC_STAGES-1] & ~tck_p1;
  assign tck_fall = ~tck_sync[SYNC_STAGES-1] & tck_p1;
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_tap_responder.sv
// Target-side JTAG TAP with IR, IDCODE, BYPASS and a USER mailbox register,
// clocked entirely by clk with TCK treated as an oversampled data signal.
module jtag_tap_responder
  import jtag_tap_responder_pkg::*;
#(
  parameter int                  IR_WIDTH      = 4,
  parameter logic [31:0]         IDCODE_VALUE  = 32'h10001FFF,
  parameter logic [IR_WIDTH-1:0] IR_IDCODE     = IR_WIDTH'(IR_IDCODE_DEFAULT),
  parameter logic [IR_WIDTH-1:0] IR_USER       = IR_WIDTH'(IR_USER_DEFAULT),
  parameter int                  USER_DR_WIDTH = 32,
  parameter int                  SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     jtag_tck,
  input  logic                     jtag_tms,
  input  logic                     jtag_tdi,
  output logic                     jtag_tdo,
  output logic                     jtag_tdo_oe,
  input  logic [USER_DR_WIDTH-1:0] user_capture_data,
  output logic [USER_DR_WIDTH-1:0] user_update_data,
  output logic                     user_update_valid,
  output logic [3:0]               tap_state
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  logic tck_rise, tck_fall, tms_s, tdi_s;

  jtag_tap_responder_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .clk      (clk),
    .reset    (reset),
    .jtag_tck (jtag_tck),
    .jtag_tms (jtag_tms),
    .jtag_tdi (jtag_tdi),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s)
  );

  tap_state_e               state, state_nxt;
  logic [IR_WIDTH-1:0]      ir, ir_sh;
  logic [31:0]              id_sh;
  logic [USER_DR_WIDTH-1:0] user_sh;
  logic                     byp_sh;
  logic                     sel_id, sel_user, dr_lsb;

  // IDCODE wins if both opcodes are ever set equal; anything else is BYPASS
  assign sel_id   = (ir == IR_IDCODE);
  assign sel_user = (ir == IR_USER) && !sel_id;
  assign dr_lsb   = sel_id ? id_sh[0] : (sel_user ? user_sh[0] : byp_sh);
  assign tap_state = state;

  // TAP state register, advanced only on the synced TCK rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         state <= TAP_RESET;
    else if (tck_rise) state <= state_nxt;
  end

  // IEEE 1149.1 next-state function on synced TMS
  always_comb begin
    state_nxt = state;
    case (state)
      TAP_RESET:      state_nxt = tms_s ? TAP_RESET     : TAP_RUN_IDLE;
      TAP_RUN_IDLE:   state_nxt = tms_s ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_DR:  state_nxt = tms_s ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: state_nxt = tms_s ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   state_nxt = tms_s ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   state_nxt = tms_s ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   state_nxt = tms_s ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   state_nxt = tms_s ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  state_nxt = tms_s ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_IR:  state_nxt = tms_s ? TAP_RESET     : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: state_nxt = tms_s ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   state_nxt = tms_s ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   state_nxt = tms_s ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   state_nxt = tms_s ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   state_nxt = tms_s ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  state_nxt = tms_s ? TAP_SELECT_DR : TAP_RUN_IDLE;
    endcase
  end

  // Instruction register: loaded at Update-IR, forced to IDCODE on entering Test-Logic-Reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= IR_IDCODE;
    end else if (tck_rise) begin
      if (state_nxt == TAP_RESET)     ir <= IR_IDCODE;
      else if (state == TAP_UPDATE_IR) ir <= ir_sh;
    end
  end

  // Capture/shift of IR and data shifters, acting on the pre-advance state
  always_ff @(posedge clk) begin
    if (tck_rise) begin
      case (state)
        TAP_CAPTURE_IR: ir_sh <= IR_CAPTURE;
        TAP_SHIFT_IR:   ir_sh <= {tdi_s, ir_sh[IR_WIDTH-1:1]};
        TAP_CAPTURE_DR: begin
          if (sel_id)        id_sh   <= IDCODE_VALUE;
          else if (sel_user) user_sh <= user_capture_data;
          else               byp_sh  <= 1'b0;
        end
        TAP_SHIFT_DR: begin
          if (sel_id)        id_sh   <= {tdi_s, id_sh[31:1]};
          else if (sel_user) user_sh <= {tdi_s, user_sh[USER_DR_WIDTH-1:1]};
          else               byp_sh  <= tdi_s;
        end
        default: ;
      endcase
    end
  end

  // USER update register and its one-clk valid pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      user_update_data  <= '0;
      user_update_valid <= 1'b0;
    end else begin
      user_update_valid <= 1'b0;
      if (tck_rise && (state == TAP_UPDATE_DR) && sel_user) begin
        user_update_data  <= user_sh;
        user_update_valid <= 1'b1;
      end
    end
  end

  // TDO launched on the synced TCK fall so it is stable at the initiator's next rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jtag_tdo    <= 1'b0;
      jtag_tdo_oe <= 1'b0;
    end else if (tck_fall) begin
      if (is_shift(state)) begin
        jtag_tdo    <= (state == TAP_SHIFT_IR) ? ir_sh[0] : dr_lsb;
        jtag_tdo_oe <= 1'b1;
      end else begin
        jtag_tdo    <= 1'b0;
        jtag_tdo_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: bit-bangs TCK/TMS/TDI and checks TDO,
// TAP state, IR effects and the USER update handshake.
module tb_jtag_tap_responder;
  import jtag_tap_responder_pkg::*;

  localparam int HALF = 5;  // clk cycles per TCK level

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        jtag_tck = 1'b0, jtag_tms = 1'b1, jtag_tdi = 1'b0;
  logic        jtag_tdo, jtag_tdo_oe;
  logic [31:0] user_capture_data = '0;
  logic [31:0] user_update_data;
  logic        user_update_valid;
  logic [3:0]  tap_state;

  int n_chk = 0;
  int n_fail = 0;
  int vld_cnt = 0;

  jtag_tap_responder dut (
    .clk               (clk),
    .reset             (reset),
    .jtag_tck          (jtag_tck),
    .jtag_tms          (jtag_tms),
    .jtag_tdi          (jtag_tdi),
    .jtag_tdo          (jtag_tdo),
    .jtag_tdo_oe       (jtag_tdo_oe),
    .user_capture_data (user_capture_data),
    .user_update_data  (user_update_data),
    .user_update_valid (user_update_valid),
    .tap_state         (tap_state)
  );

  always #5 clk = ~clk;

  // counts clk cycles with the valid pulse high
  always @(posedge clk) if (user_update_valid) vld_cnt <= vld_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One TCK period; TDO/OE are sampled just before the rising edge
  task automatic tck_bit(input logic tms, input logic tdi, output logic tdo, output logic oe);
    jtag_tms = tms;
    jtag_tdi = tdi;
    wait_clk(HALF);
    tdo = jtag_tdo;
    oe  = jtag_tdo_oe;
    jtag_tck = 1'b1;
    wait_clk(HALF);
    jtag_tck = 1'b0;
  endtask

  task automatic tms_seq(input int n, input logic [7:0] bits);
    logic t, o;
    for (int i = 0; i < n; i++) tck_bit(bits[i], 1'b0, t, o);
  endtask

  // Shift n bits LSB-first; last bit uses last_tms
  task automatic shift_bits(input int n, input logic [63:0] din, input logic last_tms,
                            output logic [63:0] dout, output logic oe_all);
    logic t, o;
    dout = '0;
    oe_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      tck_bit((i == n - 1) ? last_tms : 1'b0, din[i], t, o);
      dout[i] = t;
      oe_all &= o;
    end
  endtask

  logic [63:0] dout;
  logic        oe_all, t, o;
  int          vld_base;

  initial begin
    // reset state
    wait_clk(4);
    chk("rst_state", 64'(tap_state), 64'(TAP_RESET));
    chk("rst_tdo", 64'(jtag_tdo), 64'd0);
    chk("rst_oe", 64'(jtag_tdo_oe), 64'd0);
    chk("rst_upd", 64'(user_update_data), 64'd0);
    chk("rst_vld", 64'(user_update_valid), 64'd0);
    reset = 1'b0;
    wait_clk(4);

    // 1: five TMS=1 clocks stay in TLR, TDO never enabled
    oe_all = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tck_bit(1'b1, 1'b0, t, o);
      oe_all |= o;
    end
    wait_clk(HALF);
    chk("t1_state", 64'(tap_state), 64'(TAP_RESET));
    chk("t1_oe", 64'(oe_all | jtag_tdo_oe), 64'd0);

    // 2: IDCODE readout from TLR (bits: 0 RTI, 1 SelDR, 0 CapDR, 0 ShDR)
    tms_seq(4, 8'b0010);
    chk("t2_state", 64'(tap_state), 64'(TAP_SHIFT_DR));
    shift_bits(32, 64'd0, 1'b1, dout, oe_all);
    chk("t2_idcode", dout, 64'h10001FFF);
    chk("t2_oe", 64'(oe_all), 64'd1);
    chk("t2_exit1", 64'(tap_state), 64'(TAP_EXIT1_DR));
    tms_seq(2, 8'b01);  // Update-DR, RTI
    chk("t2_rti", 64'(tap_state), 64'(TAP_RUN_IDLE));

    // 3: IR=1111 (BYPASS); capture pattern shifts out of IR
    tms_seq(4, 8'b0011);  // SelDR, SelIR, CapIR, ShIR
    chk("t3_shir", 64'(tap_state), 64'(TAP_SHIFT_IR));
    shift_bits(4, 64'(IR_BYPASS_DEFAULT), 1'b1, dout, oe_all);
    chk("t3_ircap", dout, 64'h1);
    tms_seq(2, 8'b01);
    tms_seq(3, 8'b001);   // SelDR, CapDR, ShDR
    shift_bits(4, 64'b1101, 1'b1, dout, oe_all);
    chk("t3_bypass", dout, 64'b1010);
    tms_seq(2, 8'b01);

    // 4: USER capture/shift/update
    user_capture_data = 32'hCAFEF00D;
    tms_seq(4, 8'b0011);
    shift_bits(4, 64'b1000, 1'b1, dout, oe_all);
    tms_seq(2, 8'b01);
    tms_seq(3, 8'b001);
    vld_base = vld_cnt;
    shift_bits(32, 64'h12345678, 1'b1, dout, oe_all);
    chk("t4_capture", dout, 64'hCAFEF00D);
    chk("t4_no_early_vld", 64'(vld_cnt - vld_base), 64'd0);
    tms_seq(2, 8'b01);
    chk("t4_upd_data", 64'(user_update_data), 64'h12345678);
    chk("t4_vld_pulse", 64'(vld_cnt - vld_base), 64'd1);

    // 5: Capture-IR bits, then 5x TMS=1 from Shift-IR back to TLR (IR -> IDCODE)
    tms_seq(4, 8'b0011);
    shift_bits(4, 64'b0001, 1'b0, dout, oe_all);
    chk("t5_ircap", dout, 64'b0001);
    chk("t5_still_shir", 64'(tap_state), 64'(TAP_SHIFT_IR));
    tms_seq(5, 8'b11111);
    chk("t5_tlr", 64'(tap_state), 64'(TAP_RESET));
    tms_seq(4, 8'b0010);
    shift_bits(32, 64'd0, 1'b1, dout, oe_all);
    chk("t5_idcode", dout, 64'h10001FFF);
    tms_seq(2, 8'b01);

    // 6: reset in the middle of a USER shift
    tms_seq(4, 8'b0011);
    shift_bits(4, 64'b1000, 1'b1, dout, oe_all);
    tms_seq(2, 8'b01);
    tms_seq(3, 8'b001);
    vld_base = vld_cnt;
    for (int i = 0; i < 16; i++) tck_bit(1'b0, 1'b1, t, o);
    jtag_tck = 1'b1;
    wait_clk(2);
    reset = 1'b1;
    wait_clk(3);
    jtag_tck = 1'b0;
    jtag_tms = 1'b0;
    wait_clk(HALF);
    chk("t6_state", 64'(tap_state), 64'(TAP_RESET));
    chk("t6_tdo", 64'(jtag_tdo), 64'd0);
    chk("t6_oe", 64'(jtag_tdo_oe), 64'd0);
    reset = 1'b0;
    wait_clk(HALF);
    chk("t6_no_vld", 64'(vld_cnt - vld_base), 64'd0);
    tms_seq(4, 8'b0010);
    shift_bits(32, 64'd0, 1'b1, dout, oe_all);
    chk("t6_idcode", dout, 64'h10001FFF);
    tms_seq(2, 8'b01);
    chk("t6_no_vld_after", 64'(vld_cnt - vld_base), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
